// File: rtl/mem_bus_responder.sv
// Single-port word memory serving a shared tri-state bus and a host side port, with a
// zero-fill sequencer. Define MEM_ACCESS_STATS_EN to add saturating rd_count/wr_count outputs.
module mem_bus_responder #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATABUS_WIDTH = 32,
  parameter int DEPTH         = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_w,
  input  logic                     mem_sel,
  inout  wire  [ADDR_WIDTH-1:0]    address_bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus,
  input  logic                     host_we,
  input  logic                     host_re,
  input  logic [ADDR_WIDTH-1:0]    host_addr,
  input  logic [DATABUS_WIDTH-1:0] host_wdata,
  output logic                     host_ready,
  output logic [DATABUS_WIDTH-1:0] host_rdata,
  output logic                     host_rvalid,
  input  logic                     clear_start,
  output logic                     clear_busy,
  output logic                     err_oob
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [31:0]              rd_count,
  output logic [31:0]              wr_count
`endif
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_PTR = IW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e                   state_q;
  logic [IW-1:0]            ptr_q;
  logic                     clear_busy_q;
  logic                     err_oob_q;
  logic                     host_rvalid_q;
  logic [DATABUS_WIDTH-1:0] host_rdata_q;
  logic [DATABUS_WIDTH-1:0] mem_q [DEPTH];

  logic                     bus_rd, bus_wr, bus_in_range, host_in_range;
  logic                     host_rd_acc, host_wr_acc;
  logic [IW-1:0]            bus_idx, host_idx;
  logic [DATABUS_WIDTH-1:0] bus_rdata;

  assign bus_rd        = mem_sel & ~mem_w;
  assign bus_wr        = mem_w;
  assign bus_in_range  = {1'b0, address_bus} < DEPTH_A;
  assign host_in_range = {1'b0, host_addr} < DEPTH_A;
  assign bus_idx       = address_bus[IW-1:0];
  assign host_idx      = host_addr[IW-1:0];
  assign bus_rdata     = bus_in_range ? mem_q[bus_idx] : '0;

  // The responder only ever drives data_bus, and only during an active read.
  assign data_bus = (bus_rd && !rst) ? bus_rdata : 'z;

  assign host_ready  = ~bus_wr & ~clear_busy_q;
  assign host_rd_acc = host_ready & host_re;
  assign host_wr_acc = host_ready & host_we & ~host_re;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      clear_busy_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_start) begin
            state_q      <= ST_CLEAR;
            ptr_q        <= '0;
            clear_busy_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (ptr_q == LAST_PTR) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            clear_busy_q <= 1'b0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      err_oob_q     <= 1'b0;
    end else begin
      host_rvalid_q <= host_rd_acc;
      if (host_rd_acc) host_rdata_q <= host_in_range ? mem_q[host_idx] : '0;
      err_oob_q <= (bus_rd | bus_wr) & ~bus_in_range;
    end
  end

  // Later assignments win: a bus write to the word being cleared keeps its data.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) mem_q[ptr_q] <= '0;
    if (host_wr_acc && host_in_range) mem_q[host_idx] <= host_wdata;
    if (bus_wr && bus_in_range) mem_q[bus_idx] <= data_bus;
  end

  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign err_oob     = err_oob_q;
  assign clear_busy  = clear_busy_q;

`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] rd_count_q, wr_count_q;
  logic        clear_acc;

  assign clear_acc = (state_q == ST_IDLE) & clear_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (clear_acc) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if (bus_rd && rd_count_q != '1) rd_count_q <= rd_count_q + 1'b1;
      if (bus_wr && bus_in_range && wr_count_q != '1) wr_count_q <= wr_count_q + 1'b1;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, bus address width.
REQ-002 Parameter DATABUS_WIDTH, default 32, stored word and data bus width.
REQ-003 Parameter DEPTH, default 256 (at most 2**ADDR_WIDTH), number of implemented words.
REQ-004 Port clk, input, 1, single clock; all state on rising edge.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port mem_w, input, 1, bus write strobe from the accelerator initiator.
REQ-007 Port mem_sel, input, 1, bus read select from the initiator.
REQ-008 Port address_bus, inout, ADDR_WIDTH, word address; the responder never drives it (always high-Z).
REQ-009 Port data_bus, inout, DATABUS_WIDTH, read data (driven by the responder) or write data (driven by the initiator).
REQ-010 Host port signals: host_we (in, 1); host_re (in, 1); host_addr (in, ADDR_WIDTH); host_wdata (in, DATABUS_WIDTH); host_ready (out, 1); host_rdata (out, DATABUS_WIDTH); host_rvalid (out, 1).
REQ-011 Port clear_start, input, 1, zero-fill request.
REQ-012 Port clear_busy, output, 1, high while zero-fill runs.
REQ-013 Port err_oob, output, 1, one-cycle pulse on an out-of-range bus access.

Function
REQ-014 Bus read is active when mem_sel=1 and mem_w=0; data_bus is then driven combinationally with mem[address_bus], zero latency; otherwise data_bus is high-Z.
REQ-015 Bus write is active when mem_w=1, regardless of mem_sel; mem[address_bus] <= data_bus at the rising edge.
REQ-016 Out-of-range access (address_bus >= DEPTH): a read drives 0, a write is dropped, and err_oob=1 for the following cycle.
REQ-017 A bus read and a write to the same address in one cycle: the read returns the pre-edge contents.
REQ-018 host_ready=0 when a bus write is active or clear_busy=1; otherwise host_ready=1.
REQ-019 A host access is accepted only when host_ready=1; a host read has priority if host_we and host_re are both set.
REQ-020 Accepted host write: mem[host_addr] <= host_wdata at the edge; an out-of-range address is dropped silently.
REQ-021 Accepted host read: host_rdata is set to mem[host_addr] (0 if out of range) and host_rvalid=1 one cycle later for one cycle; host_rdata holds until the next read.
REQ-022 FSM states are IDLE and CLEAR. IDLE moves to CLEAR on clear_start. In CLEAR, one word is zeroed per cycle at address ptr 0..DEPTH-1. After ptr=DEPTH-1 the FSM returns to IDLE. Total duration is DEPTH cycles.
REQ-023 clear_busy=1 exactly while in CLEAR; clear_start is ignored while in CLEAR.
REQ-024 During CLEAR, bus reads and writes stay serviced; a bus write to the current ptr address wins over the zero.

Reset
REQ-025 On rst: FSM to IDLE, ptr=0, host_rvalid=0, host_rdata=0, err_oob=0, clear_busy=0.
REQ-026 Memory contents are not reset; reset during CLEAR leaves memory partially cleared.
REQ-027 During reset data_bus is high-Z.

Configuration
REQ-028 With MEM_ACCESS_STATS_EN defined, the block adds outputs rd_count and wr_count (32 bits each), reset to 0. They count accepted bus reads (per active cycle) and bus writes (in-range only), saturate at all-ones, and clear on clear_start acceptance.
REQ-029 Without MEM_ACCESS_STATS_EN, these ports and counters are absent and all other behaviour is identical.

Verification
REQ-030 Host writes 0x0000_0005 to addr 3, then mem_sel=1, mem_w=0, address_bus=3 -> data_bus=0x0000_0005 in the same cycle.
REQ-031 mem_w=1, address_bus=0x10, data_bus=0xFFFF_FFF9; next cycle host read of 0x10 -> host_rvalid one cycle later with host_rdata=0xFFFF_FFF9; host_ready=0 during the bus write.
REQ-032 DEPTH=16, bus write to 0x20 -> err_oob pulse; host read of 0x20 returns 0.
REQ-033 clear_start with DEPTH=16 -> clear_busy high for 16 cycles. A bus write of 0x7 to addr 5, issued when ptr=5, survives. All other words read 0.
REQ-034 Assert rst at ptr=8 during CLEAR -> clear_busy=0 immediately; words 0-7 read 0 and words 8+ hold old data.
REQ-035 With MEM_ACCESS_STATS_EN defined, 16 read cycles plus 16 write cycles -> rd_count=16 and wr_count=16; clear_start then sets both to 0.
